// File: rtl/npc_unit_if.sv
// npc_unit_if: groups the D-stage redirect request, exception controls and
// the F-stage fetch outputs of the next-PC unit.
//   master : pipeline side (drives stall/redirect/exception, reads fetch PC)
//   slave  : npc_unit side
// Signals:
//   stall, d_pc, op, cmp_eq, imm26, rs_val, exc_req, eret, epc  (master -> slave)
//   f_pc, imem_addr, taken, pend_valid, f_adel                  (slave -> master)
interface npc_unit_if #(
  parameter int WIDTH   = 32,
  parameter int IADDR_W = 12
);
  logic               stall;
  logic [WIDTH-1:0]   d_pc;
  logic [2:0]         op;
  logic               cmp_eq;
  logic [25:0]        imm26;
  logic [WIDTH-1:0]   rs_val;
  logic               exc_req;
  logic               eret;
  logic [WIDTH-1:0]   epc;
  logic [WIDTH-1:0]   f_pc;
  logic [IADDR_W-1:0] imem_addr;
  logic               taken;
  logic               pend_valid;
  logic               f_adel;

  modport master (
    output stall, d_pc, op, cmp_eq, imm26, rs_val, exc_req, eret, epc,
    input  f_pc, imem_addr, taken, pend_valid, f_adel
  );

  modport slave (
    input  stall, d_pc, op, cmp_eq, imm26, rs_val, exc_req, eret, epc,
    output f_pc, imem_addr, taken, pend_valid, f_adel
  );
endinterface

// File: rtl/npc_unit.sv
// npc_unit: F-stage PC register and next-PC generator for the pipelined MIPS
// core (delay-slot architecture: a D-stage redirect replaces the PC after the
// one already being fetched; nothing is flushed).
// Ports:
//   clk      rising-edge clock
//   reset_n  asynchronous active-low reset
//   bus      npc_unit_if.slave (redirect request in, fetch PC/status out)
// Next-PC priority: exc_req > eret > stall(hold, buffer redirect) > taken >
// buffered redirect > f_pc + 4.
// Optional feature macro: NPC_ADEL_EN -- enables fetch address-error detection
// (misaligned or outside the instruction memory window); otherwise f_adel=0.
module npc_unit #(
  parameter int               WIDTH      = 32,
  parameter logic [WIDTH-1:0] RESET_PC   = 'h0000_3000,
  parameter logic [WIDTH-1:0] IMEM_BASE  = 'h0000_3000,
  parameter int               IADDR_W    = 12,
  parameter logic [WIDTH-1:0] EXC_VECTOR = 'h0000_4180
) (
  input  logic             clk,
  input  logic             reset_n,
  npc_unit_if.slave        bus
);

  localparam logic [2:0] OP_BEQ = 3'd1;
  localparam logic [2:0] OP_BNE = 3'd2;
  localparam logic [2:0] OP_J   = 3'd3;
  localparam logic [2:0] OP_JR  = 3'd4;

  // Redirect buffer state: a taken transfer seen during a stall waits here.
  typedef enum logic {S_IDLE, S_PEND} pend_state_t;

  pend_state_t      st, st_nxt;
  logic [WIDTH-1:0] f_pc, pc_nxt;
  logic [WIDTH-1:0] pend_target, pend_nxt;
  logic [WIDTH-1:0] br_off, br_tgt, j_tgt, target;
  logic             taken;

  // Branch offset: sign-extended imm16 scaled to bytes.
  assign br_off = {{(WIDTH-18){bus.imm26[15]}}, bus.imm26[15:0], 2'b00};
  assign br_tgt = bus.d_pc + WIDTH'(4) + br_off;
  assign j_tgt  = {bus.d_pc[WIDTH-1:28], bus.imm26, 2'b00};

  always_comb begin
    taken  = 1'b0;
    target = br_tgt;
    unique case (bus.op)
      OP_BEQ:  taken = bus.cmp_eq;
      OP_BNE:  taken = !bus.cmp_eq;
      OP_J:    begin taken = 1'b1; target = j_tgt; end
      OP_JR:   begin taken = 1'b1; target = bus.rs_val; end
      default: taken = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st          <= S_IDLE;
      f_pc        <= RESET_PC;
      pend_target <= '0;
    end else begin
      st          <= st_nxt;
      f_pc        <= pc_nxt;
      pend_target <= pend_nxt;
    end
  end

  always_comb begin
    pc_nxt   = f_pc + WIDTH'(4);
    st_nxt   = st;
    pend_nxt = pend_target;
    if (bus.exc_req) begin
      pc_nxt = EXC_VECTOR;
      st_nxt = S_IDLE;
    end else if (bus.eret) begin
      pc_nxt = bus.epc;
      st_nxt = S_IDLE;
    end else if (bus.stall) begin
      pc_nxt = f_pc;
      // Latest taken redirect during a stall wins.
      if (taken) begin
        pend_nxt = target;
        st_nxt   = S_PEND;
      end
    end else if (taken) begin
      pc_nxt = target;
      st_nxt = S_IDLE;
    end else if (st == S_PEND) begin
      pc_nxt = pend_target;
      st_nxt = S_IDLE;
    end
  end

  assign bus.f_pc       = f_pc;
  assign bus.taken      = taken;
  assign bus.pend_valid = (st == S_PEND);
  assign bus.imem_addr  = IADDR_W'((f_pc - IMEM_BASE) >> 2);

`ifdef NPC_ADEL_EN
  // Offset above the base must fit in IADDR_W word-index bits plus the byte
  // offset; any higher bit set means past the end of instruction memory.
  logic [WIDTH-1:0] imem_off;
  assign imem_off   = f_pc - IMEM_BASE;
  assign bus.f_adel = (imem_off[1:0] != 2'b00) || (f_pc < IMEM_BASE) ||
                      (imem_off[WIDTH-1:IADDR_W+2] != '0);
`else
  assign bus.f_adel = 1'b0;
`endif

endmodule
